way_age_counter: RTL and testbench

WAY_AGE_COUNTER -- requirements
Module: way_age_counter

---
 rtl/way_age_counter.sv | 122 ++++++++++++
 tb/tb_way_age_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/way_age_counter.sv
// Per-way age tracker for replacement selection.
// Each valid way carries a saturating age. A fill or a hit resets the touched way's age
// to 0 and ages every other valid way. Invalid ways always hold age 0.
// A flush clears one way per cycle, walking from way 0 to way NUM_WAY-1.
module way_age_counter #(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned NUM_WAY                  = 16,
  localparam int unsigned IDX_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic                                        flush_in,
  input  logic                                        invalidate_valid_in,
  input  logic [IDX_W-1:0]                            invalidate_way_in,
  input  logic                                        fill_valid_in,
  input  logic [IDX_W-1:0]                            fill_way_in,
  input  logic                                        access_valid_in,
  input  logic [IDX_W-1:0]                            access_way_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_out,
  output logic [NUM_WAY-1:0]                          condition_out,
  output logic                                        busy_out,
  output logic                                        flush_done_out
);

  localparam int unsigned W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam logic [W-1:0] AgeMax = '1;
  localparam logic [IDX_W-1:0] LastWay = IDX_W'(NUM_WAY - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   flush_cnt_q;
  logic [W-1:0]       age_q [NUM_WAY];
  logic [W-1:0]       age_inc [NUM_WAY];
  logic [NUM_WAY-1:0] valid_q;
  logic               busy_q;
  logic               done_q;

  // Indices beyond NUM_WAY-1 can only occur when NUM_WAY is not a power of two.
  logic inv_ok, fill_ok, acc_ok;
  assign inv_ok  = 32'(invalidate_way_in) < NUM_WAY;
  assign fill_ok = 32'(fill_way_in) < NUM_WAY;
  assign acc_ok  = (32'(access_way_in) < NUM_WAY) && valid_q[access_way_in];

  // Saturating age increment for every way.
  always_comb begin
    for (int i = 0; i < NUM_WAY; i++) begin
      age_inc[i] = (age_q[i] == AgeMax) ? age_q[i] : age_q[i] + 1'b1;
    end
  end

  // Control FSM together with age/valid state; all outputs are registered.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_WAY; i++) age_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_in) begin
            state_q     <= StFlush;
            busy_q      <= 1'b1;
            flush_cnt_q <= '0;
          end else if (invalidate_valid_in) begin
            if (inv_ok) begin
              valid_q[invalidate_way_in] <= 1'b0;
              age_q[invalidate_way_in]   <= '0;
            end
          end else if (fill_valid_in) begin
            if (fill_ok) begin
              // Refilling an already-valid way is treated as a fresh allocation.
              for (int i = 0; i < NUM_WAY; i++) begin
                if (IDX_W'(i) == fill_way_in) begin
                  valid_q[i] <= 1'b1;
                  age_q[i]   <= '0;
                end else if (valid_q[i]) begin
                  age_q[i] <= age_inc[i];
                end
              end
            end
          end else if (access_valid_in && acc_ok) begin
            for (int i = 0; i < NUM_WAY; i++) begin
              if (IDX_W'(i) == access_way_in) begin
                age_q[i] <= '0;
              end else if (valid_q[i]) begin
                age_q[i] <= age_inc[i];
              end
            end
          end
        end
        StFlush: begin
          // Every request strobe, flush_in included, is ignored while flushing.
          valid_q[flush_cnt_q] <= 1'b0;
          age_q[flush_cnt_q]   <= '0;
          if (flush_cnt_q == LastWay) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_WAY; g++) begin : g_flat
    assign way_flatted_out[g*W +: W] = age_q[g];
  end

  assign condition_out  = valid_q;
  assign busy_out       = busy_q;
  assign flush_done_out = done_q;

endmodule

// File: tb/tb_way_age_counter.sv
// Directed bench for way_age_counter (defaults: 4-bit ages, 16 ways).
// Each driven cycle runs a behavioural reference model, pushes the predicted outputs to a
// queue, then pops and compares them against the DUT one edge later.
module tb_way_age_counter;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        inv_v;
  logic [3:0]  inv_w;
  logic        fill_v;
  logic [3:0]  fill_w;
  logic        acc_v;
  logic [3:0]  acc_w;
  logic [63:0] flat;
  logic [15:0] cond;
  logic        busy;
  logic        done;

  way_age_counter dut (
    .clk_in              (clk),
    .reset_in            (reset_n),
    .flush_in            (flush),
    .invalidate_valid_in (inv_v),
    .invalidate_way_in   (inv_w),
    .fill_valid_in       (fill_v),
    .fill_way_in         (fill_w),
    .access_valid_in     (acc_v),
    .access_way_in       (acc_w),
    .way_flatted_out     (flat),
    .condition_out       (cond),
    .busy_out            (busy),
    .flush_done_out      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] flat;
    logic [15:0] cond;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_age [16];
  logic [15:0] m_valid;
  bit          m_flushing;
  int          m_cnt;
  bit          m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_age[i] = 0;
    m_valid    = '0;
    m_flushing = 0;
    m_cnt      = 0;
    m_done     = 0;
  endtask

  task automatic model_step(input bit f, input bit iv, input int iw, input bit fv, input int fw,
                            input bit av, input int aw);
    m_done = 0;
    if (m_flushing) begin
      m_valid[m_cnt] = 1'b0;
      m_age[m_cnt]   = 0;
      if (m_cnt == 15) begin
        m_flushing = 0;
        m_done     = 1;
        m_cnt      = 0;
      end else begin
        m_cnt++;
      end
    end else if (f) begin
      m_flushing = 1;
      m_cnt      = 0;
    end else if (iv) begin
      m_valid[iw] = 1'b0;
      m_age[iw]   = 0;
    end else if (fv) begin
      for (int i = 0; i < 16; i++)
        if (i != fw && m_valid[i] && m_age[i] < 15) m_age[i]++;
      m_valid[fw] = 1'b1;
      m_age[fw]   = 0;
    end else if (av && m_valid[aw]) begin
      for (int i = 0; i < 16; i++)
        if (i != aw && m_valid[i] && m_age[i] < 15) m_age[i]++;
      m_age[aw] = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 16; i++) e.flat[i*4 +: 4] = 4'(m_age[i]);
    e.cond = m_valid;
    e.busy = m_flushing;
    e.done = m_done;
    return e;
  endfunction

  // Drive one cycle of requests, predict, then compare one edge later.
  task automatic cyc(input bit f, input bit iv, input int iw, input bit fv, input int fw,
                     input bit av, input int aw, input string tag);
    exp_t e;
    @(negedge clk);
    flush  = f;
    inv_v  = iv;
    inv_w  = 4'(iw);
    fill_v = fv;
    fill_w = 4'(fw);
    acc_v  = av;
    acc_w  = 4'(aw);
    model_step(f, iv, iw, fv, fw, av, aw);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".ages"}, flat, e.flat);
    check({tag, ".cond"}, 64'(cond), 64'(e.cond));
    check({tag, ".busy"}, 64'(busy), 64'(e.busy));
    check({tag, ".done"}, 64'(done), 64'(e.done));
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  function automatic logic [3:0] age_of(input int i);
    return flat[i*4 +: 4];
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, ".ages"}, flat, 64'h0);
    check({tag, ".cond"}, 64'(cond), 64'h0);
    check({tag, ".busy"}, 64'(busy), 64'h0);
    check({tag, ".done"}, 64'(done), 64'h0);
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    inv_v   = 1'b0;
    inv_w   = '0;
    fill_v  = 1'b0;
    fill_w  = '0;
    acc_v   = 1'b0;
    acc_w   = '0;
    model_reset();
    #12;
    check_cleared("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill ways 0,1,2 back to back.
    cyc(0, 0, 0, 1, 0, 0, 0, "fill0");
    cyc(0, 0, 0, 1, 1, 0, 0, "fill1");
    cyc(0, 0, 0, 1, 2, 0, 0, "fill2");
    check("fill3.cond_const", 64'(cond), 64'h0007);
    check("fill3.age0", 64'(age_of(0)), 64'd2);
    check("fill3.age1", 64'(age_of(1)), 64'd1);
    check("fill3.age2", 64'(age_of(2)), 64'd0);

    // Hit on way 0, then a hit on invalid way 5 which must change nothing.
    cyc(0, 0, 0, 0, 0, 1, 0, "acc0");
    check("acc0.age0", 64'(age_of(0)), 64'd0);
    check("acc0.age1", 64'(age_of(1)), 64'd2);
    check("acc0.age2", 64'(age_of(2)), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 5, "acc5_invalid");
    check("acc5.unchanged", flat, 64'h0000_0000_0000_0120);

    // Saturation: way 3 ages past 15 while way 4 is refilled repeatedly.
    cyc(0, 0, 0, 1, 3, 0, 0, "fill3");
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 1, 4, 0, 0, "fill4_rep");
    check("sat.age3", 64'(age_of(3)), 64'hf);
    check("sat.age4", 64'(age_of(4)), 64'h0);
    check("sat.age5", 64'(age_of(5)), 64'h0);
    check("sat.cond", 64'(cond), 64'h001f);

    // Simultaneous invalidate/fill/access: only the invalidate lands.
    cyc(0, 1, 1, 1, 2, 1, 0, "prio");
    check("prio.cond", 64'(cond), 64'h001d);
    check("prio.age1", 64'(age_of(1)), 64'h0);
    check("prio.age0", 64'(age_of(0)), 64'hf);

    // Fill remaining ways, then flush with fills and flush_in strobes during the flush.
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, 1, k, 0, 0, "fill_all");
    check("fill_all.cond", 64'(cond), 64'hffff);
    cyc(1, 0, 0, 0, 0, 0, 0, "flush_start");
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(k == 3, 0, 0, 1, k % 16, 1, 0, "flush_run");
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("flush.busy_cycles", 64'(busy_cnt), 64'd16);
    check("flush.done_pulses", 64'(done_cnt), 64'd1);

    // The fills after the flush finished repopulate some ways; restart from a clean slate.
    for (int k = 0; k < 5; k++) cyc(0, 1, k, 0, 0, 0, 0, "clean");
    cyc(0, 0, 0, 1, 9, 0, 0, "pre_abort_fill");
    cyc(1, 0, 0, 0, 0, 0, 0, "abort_flush_start");
    for (int k = 0; k < 4; k++) idle("abort_flush_run");
    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 0, 0, 1, 7, 0, 0, "post_reset_fill");
    check("post_reset.cond", 64'(cond), 64'h0080);
    for (int k = 0; k < 20; k++) idle("post_reset_idle");

    check("sb.empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
